// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  // Register offsets, selected by a[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  // STATUS bit positions
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-bus slice seen by the UART: store strobe, byte address, store data,
// and the combinational read data / window-select returned to the core.
//   master: drives we, a, wd; receives rd, sel
//   slave : receives we, a, wd; drives rd, sel
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;

  modport master (output we, output a, output wd, input rd, input sel);
  modport slave  (input we, input a, input wd, output rd, output sel);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter.
//   push/din : write din when push (caller guarantees space or same-cycle pop)
//   pop/dout : dout shows the head; pop advances it (caller guarantees non-empty)
//   full, empty, count : occupancy, combinational from the pointers
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic [7:0]  mem_q [DEPTH];

  // Pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage; a push into a full FIFO with a same-cycle pop overwrites the
  // slot being popped, which is safe because dout is consumed at this edge.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
//   clk, reset : processor clock, asynchronous active-low reset
//   bus        : we/a/wd in, rd/sel out (rd, sel combinational from a)
//   tx         : registered serial line, idle high
//   busy       : FSM not idle or FIFO non-empty
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  reload_q, reload_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              ovf_q, ovf_d;

  logic              sel_c;
  logic [1:0]        off;
  logic              wr_en;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_W-1:0] fifo_dout;
  logic [31:0]       rd_c;
  logic              unused_ok;

  // Address decode
  assign sel_c    = (bus.a[31:4] == BASE_ADDR[31:4]);
  assign off      = bus.a[3:2];
  assign wr_en    = bus.we & sel_c;
  assign push_req = wr_en & (off == REG_TXDATA);
  assign pop      = (state_q == IDLE) & ~fifo_empty;
  assign push     = push_req & (~fifo_full | pop);

  assign unused_ok = ^{bus.a[1:0], bus.wd[31:DIV_W]};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.wd[BYTE_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      div_q    <= DIV_RESET;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
    end
  end

  // Bit-timing FSM; the divisor is captured at frame start so a DIV store
  // mid-frame only affects the next frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d  = fifo_dout;
          reload_d = div_q;
          cnt_d    = div_q;
          bit_d    = '0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          tx_d    = shift_q[0];
          cnt_d   = reload_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = reload_q;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - DIV_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Divisor and sticky overflow
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_en && off == REG_DIV)    div_d = bus.wd[DIV_W-1:0];
    if (wr_en && off == REG_STATUS) ovf_d = 1'b0;
    if (push_req && !push)          ovf_d = 1'b1;
  end

  // Read mux, zero outside the window
  always_comb begin
    rd_c = '0;
    if (sel_c) begin
      case (off)
        REG_STATUS: begin
          rd_c[ST_FULL]                  = fifo_full;
          rd_c[ST_EMPTY]                 = fifo_empty;
          rd_c[ST_BUSY]                  = (state_q != IDLE);
          rd_c[ST_OVF]                   = ovf_q;
          rd_c[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_count);
        end
        REG_DIV: rd_c[DIV_W-1:0] = div_q;
        default: rd_c = '0;
      endcase
    end
  end

  assign bus.sel = sel_c;
  assign bus.rd  = rd_c;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-timeline model (each frame is a start
// time, a divisor and a byte) predicts tx, busy, sel and rd every cycle,
// plus literal expectations for a few hand-worked cases.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0000_0200;
  localparam int          DEPTH   = 4;
  localparam int          DIV_RST = 433;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  int         m_div   = DIV_RST;
  bit         m_ovf   = 1'b0;
  bit         m_have  = 1'b0;
  longint     m_cyc   = 0;
  longint     m_start = 0;
  longint     m_end   = 0;
  int         m_fdiv  = 0;
  logic [7:0] m_byte  = 8'h00;
  bit         m_hit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_div  = DIV_RST;
      m_ovf  = 1'b0;
      m_have = 1'b0;
    end else begin
      m_cyc++;
      // The line accepts a new byte one clock after the previous frame ends
      if ((!m_have || m_cyc > m_end) && m_q.size() > 0) begin
        m_byte  = m_q.pop_front();
        m_fdiv  = m_div;
        m_start = m_cyc;
        m_end   = m_cyc + 10 * (m_div + 1);
        m_have  = 1'b1;
      end
      m_hit = bus.we && (bus.a[31:4] == BASE[31:4]);
      if (m_hit) begin
        case (bus.a[3:2])
          2'd0: if (m_q.size() < DEPTH) m_q.push_back(bus.wd[7:0]);
                else m_ovf = 1'b1;
          2'd1: m_ovf = 1'b0;
          2'd2: m_div = int'(bus.wd[15:0]);
          default: ;
        endcase
      end
    end
  end

  function automatic logic m_active();
    return m_have && (m_cyc < m_end);
  endfunction

  function automatic logic m_line();
    longint idx;
    if (!m_active()) return 1'b1;
    idx = (m_cyc - m_start) / (m_fdiv + 1);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[int'(idx - 1)];
  endfunction

  function automatic logic m_busy();
    return m_active() || (m_q.size() != 0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] addr);
    logic [31:0] s;
    s = '0;
    case (addr[3:2])
      2'd1: begin
        s[0]   = (m_q.size() == DEPTH);
        s[1]   = (m_q.size() == 0);
        s[2]   = m_active();
        s[3]   = m_ovf;
        s[7:4] = 4'(m_q.size());
      end
      2'd2: s = {16'h0000, 16'(m_div)};
      default: s = '0;
    endcase
    return s;
  endfunction

  // Continuous comparison, mid low phase
  always @(negedge clk) begin
    #2;
    chk1("tx", tx, m_line());
    chk1("busy", busy, m_busy());
    chk1("sel", bus.sel, bus.a[31:4] == BASE[31:4]);
    if (bus.a[31:4] == BASE[31:4]) chk("rd", bus.rd, m_rd(bus.a));
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_idle();
    bus.we = 1'b0;
    bus.a  = 32'h0;
    bus.wd = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_burst(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.we = 1'b1;
      bus.a  = BASE;
      bus.wd = seed + 32'(i * 37);
    end
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b0;
    bus.a  = addr;
    #1;
    data = bus.rd;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic [31:0] r;
    int n;
    n = 0;
    while (m_busy() && n < 5000) begin
      bus_read(BASE + 32'd4, r);
      n++;
    end
    step(2);
    chk1("drain_busy", busy, 1'b0);
    chk1("drain_tx", tx, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] r;
    int          pick;
    bus_idle();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    bus_read(BASE + 32'd4, r);
    chk("status_reset", r, 32'h0000_0002);
    chk1("tx_reset", tx, 1'b1);
    bus_read(BASE + 32'd8, r);
    chk("div_reset", r, 32'd433);

    // Single frame 0x55 at DIV=3; bus_write returns just after store edge E
    bus_write(BASE + 32'd8, 32'd3);
    bus_write(BASE, 32'h55);
    chk1("tx_at_E", tx, 1'b1);
    step(1);  chk1("tx_start_E1", tx, 1'b0);
    step(4);  chk1("tx_bit0_E5", tx, 1'b1);
    step(4);  chk1("tx_bit1_E9", tx, 1'b0);
    step(24); chk1("tx_bit7_E33", tx, 1'b0);
    step(3);  chk1("tx_bit7_E36", tx, 1'b0);
    step(1);  chk1("tx_stop_E37", tx, 1'b1);
    step(3);  chk1("busy_E40", busy, 1'b1);
    step(1);  chk1("busy_E41", busy, 1'b0);

    // Five back-to-back stores; first pop lands after store 1
    bus_burst(5, 32'h0000_00A0);
    bus_read(BASE + 32'd4, r);
    chk("status_after_burst", r, 32'h0000_0045);
    drain();

    // Overflow while the line is busy, then clear via STATUS store
    bus_write(BASE, 32'h11);
    step(3);
    bus_burst(6, 32'h0000_0031);
    bus_read(BASE + 32'd4, r);
    chk("status_overflow", r, 32'h0000_004D);
    bus_write(BASE + 32'd4, $urandom);
    bus_read(BASE + 32'd4, r);
    chk("status_ovf_cleared", r, 32'h0000_0045);
    drain();

    // Reset in the middle of DATA
    bus_write(BASE, 32'hA5);
    bus_write(BASE, 32'h3C);
    step(14);
    #2 reset = 1'b0;
    #1;
    chk1("tx_async_reset", tx, 1'b1);
    chk1("busy_async_reset", busy, 1'b0);
    bus_read(BASE + 32'd4, r);
    chk("status_in_reset", r, 32'h0000_0002);
    @(negedge clk);
    reset = 1'b1;
    step(60);
    chk1("tx_after_reset", tx, 1'b1);

    // Addresses just outside the window
    bus_read(32'h0000_01FC, r);
    chk1("sel_1fc", bus.sel, 1'b0);
    bus_read(32'h0000_0210, r);
    chk1("sel_210", bus.sel, 1'b0);
    bus_write(32'h0000_01F8, 32'd5);
    bus_write(32'h0000_0210, 32'h77);
    bus_write(32'h0000_0218, 32'd9);
    bus_read(BASE + 32'd8, r);
    chk("div_unchanged", r, 32'd433);
    bus_read(BASE + 32'd4, r);
    chk("status_unchanged", r, 32'h0000_0002);

    // Randomized traffic
    bus_write(BASE + 32'd8, 32'd2);
    for (int i = 0; i < 600; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 55) begin
        @(negedge clk);
        bus.we = 1'b0;
        bus.a  = BASE + 32'($urandom_range(0, 15));
      end else if (pick < 80) begin
        bus_write(BASE + 32'($urandom_range(0, 3)), $urandom);
      end else if (pick < 85) begin
        bus_write(BASE + 32'd8, {16'($urandom), 16'($urandom_range(0, 3))});
      end else if (pick < 90) begin
        bus_write(BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
      end else if (pick < 95) begin
        bus_write(BASE + 32'd12, $urandom);
      end else begin
        case ($urandom_range(0, 2))
          0:       bus_write(32'h0000_01FC, $urandom);
          1:       bus_write(32'h0000_0210 + 32'($urandom_range(0, 15)), $urandom);
          default: bus_write($urandom, $urandom);
        endcase
      end
    end
    bus_idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
